// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parity_pkg
// Purpose : Shared types, defaults and lane-count helper for the parity pipe.
// Revision: 1.0 - initial release
// ============================================================================
package parity_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int LANE_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_e;

    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_lane_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : parity_lane_pipe_if
// Purpose : Input/output beat handshake bundle for parity_lane_pipe.
// Revision: 1.0 - initial release
// ============================================================================
interface parity_lane_pipe_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LANE_W = LANE_W_DEFAULT
) ();

    localparam int LANES = lanes(DATA_W, LANE_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [LANES-1:0]  in_par;
    logic              in_check;
    logic              odd_mode;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LANES-1:0]  out_par;
    logic [LANES-1:0]  out_err_lanes;
    logic              out_err;

    // Producer/consumer side of the pipe.
    modport master (
        output in_valid, in_data, in_par, in_check, odd_mode, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err_lanes, out_err
    );

    // The parity pipe itself.
    modport slave (
        input  in_valid, in_data, in_par, in_check, odd_mode, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err_lanes, out_err
    );

endinterface
`default_nettype wire

// File: rtl/parity_lane_calc.sv
`default_nettype none
// ============================================================================
// Module  : parity_lane_calc
// Purpose : Combinational parity of one lane, even or odd.
// Revision: 1.0 - initial release
// ============================================================================
module parity_lane_calc
    import parity_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEFAULT
) (
    input  logic [LANE_W-1:0] lane_data,
    input  parity_mode_e      mode,
    output logic              par
);

    assign par = (^lane_data) ^ (mode == PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/parity_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : parity_lane_pipe
// Purpose : Two-stage elastic per-lane parity generator/checker with sticky
//           error flag; saturating error counter built only when
//           PARITY_ERR_CNT_EN is defined (otherwise err_cnt reads 0).
// Revision: 1.0 - initial release
// ============================================================================
module parity_lane_pipe
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LANE_W = LANE_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_lane_pipe_if.slave  bus,
    input  logic               clr_err,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int LANES = lanes(DATA_W, LANE_W);

    if (DATA_W % LANE_W != 0) begin : g_width_check
        $error("parity_lane_pipe: DATA_W must be a multiple of LANE_W");
    end

    logic [LANES-1:0]  w_par;
    logic              w_s2_ready;
    logic              w_in_ready;
    logic              w_count;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [LANES-1:0]  r_s1_par;
    logic [LANES-1:0]  r_s1_in_par;
    logic              r_s1_check;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [LANES-1:0]  r_s2_par;
    logic [LANES-1:0]  r_s2_err_lanes;

    logic              r_err_sticky;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane_calc #(
            .LANE_W (LANE_W)
        ) u_calc (
            .lane_data (bus.in_data[i*LANE_W +: LANE_W]),
            .mode      (parity_mode_e'(bus.odd_mode)),
            .par       (w_par[i])
        );
    end

    // Ready flows backwards combinationally so a draining output frees both stages in one cycle.
    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_par    <= '0;
            r_s1_in_par <= '0;
            r_s1_check  <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data   <= bus.in_data;
                r_s1_par    <= w_par;
                r_s1_in_par <= bus.in_par;
                r_s1_check  <= bus.in_check;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid     <= 1'b0;
            r_s2_data      <= '0;
            r_s2_par       <= '0;
            r_s2_err_lanes <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data      <= r_s1_data;
                r_s2_par       <= r_s1_par;
                r_s2_err_lanes <= (r_s1_par ^ r_s1_in_par) & {LANES{r_s1_check}};
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_s2_valid;
    assign bus.out_data      = r_s2_data;
    assign bus.out_par       = r_s2_par;
    assign bus.out_err_lanes = r_s2_err_lanes;
    assign bus.out_err       = |r_s2_err_lanes;

    assign w_count = r_s2_valid && bus.out_ready && (|r_s2_err_lanes);

    // A clear that lands on a counted error beat keeps that beat's error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (clr_err) begin
            r_err_sticky <= w_count;
        end else if (w_count) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= w_count ? CNT_W'(1) : '0;
        end else if (w_count && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_parity_lane_pipe
// Purpose : Directed self-checking bench for parity_lane_pipe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_parity_lane_pipe;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic clr1, clr2, clr3;
    logic st1, st2, st3;
    logic [15:0] cnt1, cnt2;
    logic [1:0]  cnt3;

    int n_checks;
    int n_fail;

    parity_lane_pipe_if #(.DATA_W(32), .LANE_W(8))  b  ();
    parity_lane_pipe_if #(.DATA_W(32), .LANE_W(32)) b2 ();
    parity_lane_pipe_if #(.DATA_W(32), .LANE_W(8))  b3 ();

    parity_lane_pipe #(.DATA_W(32), .LANE_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b), .clr_err(clr1), .err_sticky(st1), .err_cnt(cnt1));
    parity_lane_pipe #(.DATA_W(32), .LANE_W(32), .CNT_W(16)) u_dut_word (
        .clk(clk), .rst_n(rst_n), .bus(b2), .clr_err(clr2), .err_sticky(st2), .err_cnt(cnt2));
    parity_lane_pipe #(.DATA_W(32), .LANE_W(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(b3), .clr_err(clr3), .err_sticky(st3), .err_cnt(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for a single cycle then waits one more edge; with out_ready=1 the beat is then on the output.
    task automatic drive_beat(input logic [31:0] d, input logic [3:0] p, input logic chk, input logic odd);
        b.in_valid = 1'b1; b.in_data = d; b.in_par = p; b.in_check = chk; b.odd_mode = odd;
        tick();
        b.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", b.out_valid); end
        n_checks++; if (b.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", b.out_data); end
        n_checks++; if (b.out_par !== 4'h0) begin n_fail++; $display("FAIL rst_out_par: got %b want 0000", b.out_par); end
        n_checks++; if (b.out_err_lanes !== 4'h0 || b.out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b/%b want 0000/0", b.out_err_lanes, b.out_err); end
        n_checks++; if (st1 !== 1'b0 || cnt1 !== 16'h0) begin n_fail++; $display("FAIL rst_err_status: got %b/%h want 0/0", st1, cnt1); end
        n_checks++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", b.in_ready); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst: got in_ready=%b out_valid=%b want 1/0", b.in_ready, b.out_valid); end
    endtask

    task automatic test_gen_even();
        b.out_ready = 1'b1;
        b.in_valid = 1'b1; b.in_data = 32'h3456_789a; b.in_par = 4'h0; b.in_check = 1'b0; b.odd_mode = 1'b0;
        tick();
        b.in_valid = 1'b0;
        n_checks++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_1cyc: got out_valid=%b want 0", b.out_valid); end
        tick();
        n_checks++; if (b.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2cyc: got out_valid=%b want 1", b.out_valid); end
        n_checks++; if (b.out_par !== 4'b1000) begin n_fail++; $display("FAIL gen_even_par: got %b want 1000", b.out_par); end
        n_checks++; if (b.out_data !== 32'h3456_789a) begin n_fail++; $display("FAIL gen_even_data: got %h want 3456789a", b.out_data); end
        n_checks++; if (b.out_err !== 1'b0) begin n_fail++; $display("FAIL gen_even_err: got %b want 0", b.out_err); end
        tick();
        n_checks++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL gen_even_drain: got out_valid=%b want 0", b.out_valid); end
    endtask

    task automatic test_gen_odd();
        drive_beat(32'h3456_789a, 4'h0, 1'b0, 1'b1);
        n_checks++; if (b.out_par !== 4'b0111) begin n_fail++; $display("FAIL gen_odd_par: got %b want 0111", b.out_par); end
        tick();
        drive_beat(32'h0000_0000, 4'h0, 1'b0, 1'b1);
        n_checks++; if (b.out_par !== 4'b1111) begin n_fail++; $display("FAIL gen_odd_zero: got %b want 1111", b.out_par); end
        tick();
        drive_beat(32'h0102_0304, 4'h0, 1'b0, 1'b0);
        n_checks++; if (b.out_par !== 4'b1101) begin n_fail++; $display("FAIL gen_even_0102: got %b want 1101", b.out_par); end
        tick();
    endtask

    task automatic test_whole_word();
        b2.in_valid = 1'b1; b2.in_data = 32'h3456_789a; b2.in_par = 1'b0; b2.in_check = 1'b0; b2.odd_mode = 1'b0;
        tick();
        b2.in_valid = 1'b0;
        tick();
        n_checks++; if (b2.out_valid !== 1'b1 || b2.out_par !== 1'b1) begin n_fail++; $display("FAIL word_even: got v=%b par=%b want 1/1", b2.out_valid, b2.out_par); end
        tick();
        b2.in_valid = 1'b1; b2.odd_mode = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        tick();
        n_checks++; if (b2.out_valid !== 1'b1 || b2.out_par !== 1'b0) begin n_fail++; $display("FAIL word_odd: got v=%b par=%b want 1/0", b2.out_valid, b2.out_par); end
        tick();
    endtask

    task automatic test_check();
        drive_beat(32'hc464_78ff, 4'b1101, 1'b1, 1'b0);
        n_checks++; if (b.out_par !== 4'b1100) begin n_fail++; $display("FAIL chk_par: got %b want 1100", b.out_par); end
        n_checks++; if (b.out_err_lanes !== 4'b0001) begin n_fail++; $display("FAIL chk_err_lanes: got %b want 0001", b.out_err_lanes); end
        n_checks++; if (b.out_err !== 1'b1) begin n_fail++; $display("FAIL chk_err: got %b want 1", b.out_err); end
        n_checks++; if (st1 !== 1'b0) begin n_fail++; $display("FAIL chk_sticky_early: got %b want 0", st1); end
        tick();
        n_checks++; if (st1 !== 1'b1) begin n_fail++; $display("FAIL chk_sticky: got %b want 1", st1); end
        n_checks++; if (cnt1 !== (CNT_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL chk_cnt: got %0d want %0d", cnt1, CNT_EN ? 1 : 0); end
        drive_beat(32'hc464_78ff, 4'b1100, 1'b1, 1'b0);
        n_checks++; if (b.out_err_lanes !== 4'b0000) begin n_fail++; $display("FAIL chk_match: got %b want 0000", b.out_err_lanes); end
        tick();
        drive_beat(32'hc464_78ff, 4'b0011, 1'b0, 1'b0);
        n_checks++; if (b.out_err_lanes !== 4'b0000 || b.out_err !== 1'b0) begin n_fail++; $display("FAIL gen_no_flag: got %b/%b want 0000/0", b.out_err_lanes, b.out_err); end
        tick();
        n_checks++; if (cnt1 !== (CNT_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL chk_cnt_hold: got %0d want %0d", cnt1, CNT_EN ? 1 : 0); end
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        n_checks++; if (st1 !== 1'b0 || cnt1 !== 16'd0) begin n_fail++; $display("FAIL clr: got %b/%0d want 0/0", st1, cnt1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv [4];
        int idx, nrecv;
        logic prev_stall, hs_in, hs_out, chk_full;
        logic [31:0] prev_data;
        dv[0] = 32'h1111_1111; dv[1] = 32'h2222_2222; dv[2] = 32'h3333_3333; dv[3] = 32'h4444_4444;
        idx = 0; nrecv = 0; prev_stall = 1'b0; prev_data = '0; chk_full = 1'b0;
        b.in_check = 1'b0; b.odd_mode = 1'b0; b.in_par = 4'h0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            b.out_ready = (cyc >= 5);
            b.in_valid  = (idx < 4);
            b.in_data   = dv[(idx < 4) ? idx : 0];
            #1;
            if (prev_stall) begin
                n_checks++; if (b.out_data !== prev_data) begin n_fail++; $display("FAIL bp_stable: got %h want %h", b.out_data, prev_data); end
            end
            if (idx == 2 && cyc < 5 && !chk_full) begin
                chk_full = 1'b1;
                n_checks++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", b.in_ready); end
            end
            if (cyc == 5) begin
                n_checks++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_rise: got %b want 1", b.in_ready); end
            end
            hs_in  = b.in_valid && b.in_ready;
            hs_out = b.out_valid && b.out_ready;
            if (hs_out) begin
                if (nrecv < 4) begin
                    n_checks++; if (b.out_data !== dv[nrecv]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", nrecv, b.out_data, dv[nrecv]); end
                end
                nrecv++;
            end
            prev_stall = b.out_valid && !b.out_ready;
            prev_data  = b.out_data;
            tick();
            if (hs_in) idx++;
        end
        b.in_valid = 1'b0;
        n_checks++; if (chk_full !== 1'b1) begin n_fail++; $display("FAIL bp_fill: got accepted-before-stall=%b want 1", chk_full); end
        n_checks++; if (nrecv != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats want 4", nrecv); end
    endtask

    task automatic test_saturation();
        b3.out_ready = 1'b1; b3.in_data = 32'h0; b3.in_par = 4'b0001; b3.in_check = 1'b1; b3.odd_mode = 1'b0;
        b3.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        b3.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (cnt3 !== (CNT_EN ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL sat_cnt: got %b want %b", cnt3, CNT_EN ? 2'b11 : 2'b00); end
        n_checks++; if (st3 !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b want 1", st3); end
        b3.in_valid = 1'b1;
        tick();
        b3.in_valid = 1'b0;
        tick();
        n_checks++; if (b3.out_valid !== 1'b1 || b3.out_err !== 1'b1) begin n_fail++; $display("FAIL sat_beat: got v=%b err=%b want 1/1", b3.out_valid, b3.out_err); end
        clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        n_checks++; if (cnt3 !== (CNT_EN ? 2'b01 : 2'b00) || st3 !== 1'b1) begin n_fail++; $display("FAIL clr_coincide: got cnt=%b st=%b want %b/1", cnt3, st3, CNT_EN ? 2'b01 : 2'b00); end
        clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        n_checks++; if (cnt3 !== 2'b00 || st3 !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got cnt=%b st=%b want 00/0", cnt3, st3); end
    endtask

    task automatic test_reset_midstream();
        b.out_ready = 1'b0; b.in_check = 1'b0; b.odd_mode = 1'b0; b.in_par = 4'h0;
        b.in_valid = 1'b1; b.in_data = 32'haaaa_0001;
        tick();
        b.in_data = 32'haaaa_0002;
        tick();
        b.in_valid = 1'b0;
        n_checks++; if (b.out_valid !== 1'b1 || b.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got v=%b rdy=%b want 1/0", b.out_valid, b.in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (b.out_valid !== 1'b0 || b.out_data !== 32'h0) begin n_fail++; $display("FAIL mid_async: got v=%b d=%h want 0/0", b.out_valid, b.out_data); end
        n_checks++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", b.in_ready); end
        tick();
        rst_n = 1'b1;
        b.out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_partial: got %b want 0", b.out_valid); end
        b.in_valid = 1'b1; b.in_data = 32'h5a5a_0003;
        tick();
        b.in_valid = 1'b0;
        n_checks++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: got %b want 0", b.out_valid); end
        tick();
        n_checks++; if (b.out_valid !== 1'b1 || b.out_data !== 32'h5a5a_0003) begin n_fail++; $display("FAIL mid_lat2: got v=%b d=%h want 1/5a5a0003", b.out_valid, b.out_data); end
        tick();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; clr1 = 1'b0; clr2 = 1'b0; clr3 = 1'b0;
        b.in_valid = 1'b0;  b.in_data = '0;  b.in_par = '0;  b.in_check = 1'b0;  b.odd_mode = 1'b0;  b.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_par = '0; b2.in_check = 1'b0; b2.odd_mode = 1'b0; b2.out_ready = 1'b1;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_par = '0; b3.in_check = 1'b0; b3.odd_mode = 1'b0; b3.out_ready = 1'b1;
        test_reset();
        test_gen_even();
        test_gen_odd();
        test_whole_word();
        test_check();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_lane_pipe.md
# parity_lane_pipe

Parametrised, pipelined parity generator/checker for address and data words. It computes one parity bit per lane across a DATA_W-bit word in even or odd mode. In check mode it compares the computed bits against received parity and flags per-lane mismatches. It sits between a valid/ready producer (bus master or address path) and its consumer, and keeps a sticky error flag and a saturating error count for status registers.

## Interface
- DATA_W, 32, word width; must be a multiple of LANE_W.
- LANE_W, 8, bits covered by each parity bit; LANE_W = DATA_W gives whole-word parity.
- CNT_W, 16, error counter width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  DATA_W  word.
- in_par  input  LANES  received parity (LANES = DATA_W/LANE_W); lane i covers in_data[i*LANE_W +: LANE_W].
- in_check  input  1  1 = check beat against in_par; 0 = generate only (never flags an error).
- odd_mode  input  1  1 = odd parity, 0 = even; sampled per beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  in_data passed through unchanged.
- out_par  output  LANES  computed parity.
- out_err_lanes  output  LANES  per-lane mismatch; all-zero when the beat's in_check = 0.
- out_err  output  1  OR of out_err_lanes.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- err_sticky  output  1  set by any accepted error beat.
- err_cnt  output  CNT_W  count of accepted error beats; saturates.

## Operation
- Even parity bit = XOR of lane bits. Odd parity bit = its complement.
- Stage 1 registers data, computed out_par, in_par, in_check and valid.
- Stage 2 registers the compare result: err_lanes = (par ^ in_par) & {LANES{check}}.
- Elastic handshake, no bubbles:
  - s2_ready = !s2_valid || out_ready
  - in_ready = !s1_valid || s2_ready
  - Ready paths are combinational; valid/data are registered.
- While out_valid = 1 and out_ready = 0, out_* stay stable.
- Error accounting occurs only on an output handshake (out_valid && out_ready && out_err): err_sticky <= 1, err_cnt <= err_cnt + 1.
- err_cnt saturates at all-ones and never wraps.
- clr_err takes priority over counting, except when clr_err coincides with a counted error beat: err_cnt <= 1 and err_sticky <= 1.
- Changing odd_mode mid-stream affects only beats accepted after the change.

## Timing
- Latency is 2 cycles from input handshake to out_valid.
- Throughput is 1 beat/cycle when out_ready = 1.
- Reset values: out_valid = 0, out_data = 0, out_par = 0, out_err_lanes = 0, out_err = 0, err_sticky = 0, err_cnt = 0.
- in_ready = 1 during and immediately after reset.
- Reset asserted mid-operation discards all in-flight beats immediately. No partial beat is emitted after release.
- Full pipeline (both stages valid) with out_ready = 0 gives in_ready = 0.
- When out_ready rises, in_ready rises in the same cycle.

## Configuration
- PARITY_ERR_CNT_EN defined: err_cnt counter is present as specified.
- PARITY_ERR_CNT_EN undefined: counter logic is omitted and err_cnt is tied to 0.
- err_sticky, out_err and out_err_lanes are unaffected by the macro.

## Structure
- Shared package parity_pkg holds:
  - function lanes(DATA_W, LANE_W)
  - enum parity_mode_e {PAR_EVEN = 0, PAR_ODD = 1}
  - localparam defaults for DATA_W, LANE_W and CNT_W
- One sub-module, parity_lane_calc: combinational, LANE_W-bit reduction plus mode select. It is instantiated LANES times via generate.
- Elaboration-time check: DATA_W % LANE_W == 0.

## Test plan
- Generate mode, even parity: in_data = 32'h3456_789a, LANE_W = 8 -> out_par = 4'b1000 two cycles after acceptance, out_err = 0.
- Same beat with odd_mode = 1 -> out_par = 4'b0111. With LANE_W = 32, even -> out_par = 1'b1 (15 ones).
- Check mode, mismatch: in_data = 32'hc464_78ff, even, in_par = 4'b1101 -> out_par = 4'b1100, out_err_lanes = 4'b0001, out_err = 1, err_cnt = 1, err_sticky = 1.
- Backpressure: 4 back-to-back beats with out_ready = 0 for 5 cycles -> in_ready falls after 2 beats; out_data is held stable; all 4 beats emerge in order with none lost or duplicated.
- Saturation: CNT_W = 2 with 5 error beats -> err_cnt = 2'b11. clr_err coinciding with an error handshake -> err_cnt = 1.
- Reset mid-stream: rst_n low with both stages valid -> out_valid = 0 asynchronously. After release, the first out_valid appears only 2 cycles after the next accepted beat.
